// File: rtl/mask_gen_pkg.sv
// Shared types and helpers for the mask_gen background-subtraction front end.
package mask_gen_pkg;

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic [23:0] MASK_FG = 24'hFFFFFF;
    localparam logic [23:0] MASK_BG = 24'h000000;

    // Luma approximation (R + 2G + B) / 4; the 10-bit sum cannot overflow.
    function automatic logic [7:0] rgb_to_gray(input logic [23:0] px);
        logic [9:0] sum;
        sum = {2'b00, px[23:16]} + {1'b0, px[15:8], 1'b0} + {2'b00, px[7:0]};
        return sum[9:2];
    endfunction

endpackage

// File: rtl/gray_diff.sv
// Combinational absolute luma difference between an image and a background pixel.
module gray_diff
    import mask_gen_pkg::*;
(
    input  logic [23:0] img,
    input  logic [23:0] bg,
    output logic [7:0]  diff
);

    logic [7:0] gray_img;
    logic [7:0] gray_bg;

    always_comb begin
        gray_img = rgb_to_gray(img);
        gray_bg  = rgb_to_gray(bg);
        diff     = (gray_img > gray_bg) ? (gray_img - gray_bg) : (gray_bg - gray_img);
    end

endmodule

// File: rtl/mask_gen.sv
// Pops paired image/background pixels, thresholds their luma difference and pushes
// ped + mask words in lockstep. Define MASK_GEN_STATS_EN to build per-frame fg stats.
//   state   | meaning
//   S_READ  | wait until both input FIFOs are non-empty, pop both and latch pixels
//   S_CALC  | compute luma difference and register the foreground decision
//   S_WRITE | wait until neither output FIFO is full, push ped and mask together
module mask_gen
    import mask_gen_pkg::*;
#(
    parameter int THRESHOLD    = 50,
    parameter int FRAME_PIXELS = 388800
) (
    input  logic        clock,
    input  logic        reset,
    output logic        in_rd_en_img,
    input  logic        in_empty_img,
    input  logic [23:0] in_dout_img,
    output logic        in_rd_en_bg,
    input  logic        in_empty_bg,
    input  logic [23:0] in_dout_bg,
    output logic        out_wr_en_ped,
    input  logic        out_full_ped,
    output logic [23:0] out_din_ped,
    output logic        out_wr_en_mask,
    input  logic        out_full_mask,
    output logic [23:0] out_din_mask,
    output logic [19:0] fg_count,
    output logic        fg_count_valid
);

    localparam logic [7:0] THRESH = THRESHOLD[7:0];

    state_t      state;
    logic [23:0] img_px;
    logic [23:0] bg_px;
    logic        mask_bit;
    logic [7:0]  diff;
    logic        do_read;
    logic        do_write;

    gray_diff u_gray_diff (
        .img  (img_px),
        .bg   (bg_px),
        .diff (diff)
    );

    // Strobes are gated by reset so nothing moves while the FSM is being cleared.
    assign do_read  = !reset && (state == S_READ)  && !in_empty_img && !in_empty_bg;
    assign do_write = !reset && (state == S_WRITE) && !out_full_ped && !out_full_mask;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_READ;
            img_px   <= '0;
            bg_px    <= '0;
            mask_bit <= 1'b0;
        end else begin
            case (state)
                S_READ: begin
                    if (do_read) begin
                        img_px <= in_dout_img;
                        bg_px  <= in_dout_bg;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    mask_bit <= (diff > THRESH);
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    if (do_write) state <= S_READ;
                end
                default: state <= S_READ;
            endcase
        end
    end

    assign in_rd_en_img   = do_read;
    assign in_rd_en_bg    = do_read;
    assign out_wr_en_ped  = do_write;
    assign out_wr_en_mask = do_write;
    assign out_din_ped    = do_write ? img_px : 24'h000000;
    assign out_din_mask   = (do_write && mask_bit) ? MASK_FG : MASK_BG;

`ifdef MASK_GEN_STATS_EN
    localparam logic [19:0] LAST_PIXEL = 20'(FRAME_PIXELS - 1);

    logic [19:0] pix_cnt;
    logic [19:0] fg_acc;
    logic [19:0] fg_reg;
    logic        frame_end;

    assign frame_end = do_write && (pix_cnt == LAST_PIXEL);

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_cnt <= '0;
            fg_acc  <= '0;
            fg_reg  <= '0;
        end else if (do_write) begin
            if (frame_end) begin
                fg_reg  <= fg_acc + {19'd0, mask_bit};
                pix_cnt <= '0;
                fg_acc  <= '0;
            end else begin
                pix_cnt <= pix_cnt + 20'd1;
                fg_acc  <= fg_acc + {19'd0, mask_bit};
            end
        end
    end

    assign fg_count       = fg_reg;
    assign fg_count_valid = frame_end;
`else
    // Frame size only matters when stats are built; keep the parameter referenced.
    if (FRAME_PIXELS < 1) begin : g_no_frame
    end

    assign fg_count       = 20'd0;
    assign fg_count_valid = 1'b0;
`endif

endmodule
